// File: rtl/mem_arb_pkg.sv
// Shared types, field offsets and the arbitration pick function for the
// memory port arbiter.
package mem_arb_pkg;

    localparam int REQ_W    = 68;
    localparam int BE_MSB   = 67;
    localparam int BE_LSB   = 64;
    localparam int ADDR_MSB = 63;
    localparam int ADDR_LSB = 32;
    localparam int DATA_MSB = 31;
    localparam int DATA_LSB = 0;

    // Requester indices are carried at the widest supported size so one
    // pick function serves every NUM_REQ in 2..4.
    localparam int MAX_REQ = 4;
    localparam int IDX_W   = 2;

    typedef struct packed {
        logic [3:0]  byte_en;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_req_t;

    // First set bit of eligible at or after ptr, wrapping. Bits at and above
    // NUM_REQ must be zero so that wrapping modulo MAX_REQ matches wrapping
    // modulo NUM_REQ. Returns ptr when nothing is eligible.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] eligible,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] pick;
        logic             found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = ptr + IDX_W'(k);
            if (!found && eligible[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// In-order tag FIFO: remembers which requester issued each outstanding put.
// The caller never pushes when full nor pops when empty.
module mem_arb_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);
    localparam logic [AW:0] DEPTH_CT = (AW+1)'(DEPTH);

    // Pointers run free; only the low AW bits address storage, so the
    // index wraps modulo DEPTH.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Next-state for pointers and occupancy; push+pop leaves count unchanged.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + ONE;
        if (pop_i)  rd_ptr_d = rd_ptr_q + ONE;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; count alone decides which entries are meaningful.
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

    assign full_o  = (count_q == DEPTH_CT);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port among NUM_REQ requesters. Grants at most one put
// per cycle, records the winner in an in-order tag FIFO and steers each
// response back to the requester whose put produced it.
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// without it the lowest eligible index wins and no rr register exists.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*REQ_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [REQ_W-1:0]         resp_data,
    output logic                     mem_put_valid,
    input  logic                     mem_put_ready,
    output logic [REQ_W-1:0]         mem_put_request,
    output logic                     mem_get_valid,
    input  logic                     mem_get_ready,
    input  logic [REQ_W-1:0]         mem_get_response,
    output logic                     err_orphan
);

    logic               full, empty;
    logic [IDX_W-1:0]   head_tag, winner, rr_ptr;
    logic [MAX_REQ-1:0] eligible, resp_ready_ext;
    logic               put_fire, get_fire;
    logic               err_orphan_q, err_orphan_d;
    mem_req_t           winner_req;

    // ---------------- put side ----------------
    // A full FIFO blocks every requester, even if a pop happens this cycle,
    // which keeps the get side out of the put path.
    assign eligible      = MAX_REQ'(req_valid & {NUM_REQ{~full}});
    assign winner        = rr_pick(eligible, rr_ptr);
    assign mem_put_valid = ~RST & (|eligible);
    assign put_fire      = mem_put_valid & mem_put_ready;

    // Steer the winner's request to memory and its ready back to it.
    always_comb begin
        winner_req = '0;
        req_ready  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IDX_W'(i)) begin
                winner_req   = req_data[i*REQ_W +: REQ_W];
                req_ready[i] = put_fire;
            end
        end
    end

    assign mem_put_request = winner_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_q, rr_d;

    // Move the search start just past the requester that actually fired.
    always_comb begin
        rr_d = rr_q;
        if (put_fire) rr_d = (winner == IDX_W'(NUM_REQ-1)) ? '0 : winner + IDX_W'(1);
    end

    // Round-robin pointer register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) rr_q <= '0;
        else     rr_q <= rr_d;
    end

    assign rr_ptr = rr_q;
`else
    assign rr_ptr = '0;
`endif

    // ---------------- get side ----------------
    assign resp_ready_ext = MAX_REQ'(resp_ready);
    assign mem_get_valid  = ~RST & ~empty & resp_ready_ext[head_tag];
    assign get_fire       = mem_get_valid & mem_get_ready;
    assign resp_data      = mem_get_response;

    // Offer the response only to the requester named by the head tag.
    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = ~RST & ~empty & mem_get_ready & (head_tag == IDX_W'(i));
        end
    end

    // A response with nothing outstanding latches the error until reset.
    always_comb begin
        err_orphan_d = err_orphan_q | (mem_get_ready & empty);
    end

    // Sticky orphan-response flag register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) err_orphan_q <= 1'b0;
        else     err_orphan_q <= err_orphan_d;
    end

    assign err_orphan = err_orphan_q;

    mem_arb_tag_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk     (CLK),
        .rst     (RST),
        .push_i  (put_fire),
        .pop_i   (get_fire),
        .din_i   (winner),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head_tag)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, all
// compared each cycle against a queue-based reference model. The bench also
// plays the memory, answering accepted puts in order.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int MAX_OUT = 4;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic                     CLK = 1'b0;
    logic                     RST;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*REQ_W-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [NUM_REQ-1:0]       resp_ready;
    logic [REQ_W-1:0]         resp_data;
    logic                     mem_put_valid;
    logic                     mem_put_ready;
    logic [REQ_W-1:0]         mem_put_request;
    logic                     mem_get_valid;
    logic                     mem_get_ready;
    logic [REQ_W-1:0]         mem_get_response;
    logic                     err_orphan;

    mem_port_arbiter #(.NUM_REQ(NUM_REQ), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_data        (resp_data),
        .mem_put_valid    (mem_put_valid),
        .mem_put_ready    (mem_put_ready),
        .mem_put_request  (mem_put_request),
        .mem_get_valid    (mem_get_valid),
        .mem_get_ready    (mem_get_ready),
        .mem_get_response (mem_get_response),
        .err_orphan       (err_orphan)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who owns each outstanding put, and the memory's
    // pending responses in acceptance order.
    int           tagq[$];
    logic [67:0]  memq[$];
    int           rr = 0;
    bit           orphan = 1'b0;

    // DUT values seen in the most recent cycle, for directed checks.
    logic [NUM_REQ-1:0] obs_req_ready, obs_resp_valid;
    logic               obs_put_valid, obs_get_valid, obs_orphan;
    logic [REQ_W-1:0]   obs_resp_data;

    task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [67:0] rand68();
        return {4'($urandom), $urandom(), $urandom()};
    endfunction

    // The memory's answer to a request: anything deterministic and distinct.
    function automatic logic [67:0] mk_resp(input logic [67:0] req);
        return {~req[67:64], req[63:32], req[31:0] ^ req[63:32] ^ 32'h5EED_0000};
    endfunction

    // One clock cycle: inputs already driven; compare outputs with the model,
    // cross the rising edge, advance the model, return at the falling edge.
    task automatic tick();
        int n, w, h;
        bit pv, pf, gv, gf;
        logic [NUM_REQ-1:0] exp_ready, exp_rv;
        logic [67:0]        exp_req;
        mem_get_response = (memq.size() > 0) ? memq[0] : 68'h0;
        #1;
        n = tagq.size();
        w = -1;
        exp_req = '0;
        if (n < MAX_OUT) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int idx;
                idx = (rr + k) % NUM_REQ;
                if (w < 0 && req_valid[idx]) w = idx;
            end
        end
        pv = !RST && (w >= 0);
        pf = pv && mem_put_ready;
        exp_ready = pf ? NUM_REQ'(1 << w) : '0;
        if (pv) exp_req = req_data[w*REQ_W +: REQ_W];
        h  = (n > 0) ? tagq[0] : 0;
        gv = !RST && (n > 0) && resp_ready[h];
        gf = gv && mem_get_ready;
        exp_rv = (!RST && n > 0 && mem_get_ready) ? NUM_REQ'(1 << h) : '0;

        check("put_valid", mem_put_valid, pv);
        check("req_ready", req_ready, exp_ready);
        if (pv) check("put_request", mem_put_request, exp_req);
        check("get_valid", mem_get_valid, gv);
        check("resp_valid", resp_valid, exp_rv);
        if (exp_rv != '0) check("resp_data", resp_data, memq[0]);
        check("err_orphan", err_orphan, !RST && orphan);

        obs_req_ready  = req_ready;
        obs_resp_valid = resp_valid;
        obs_put_valid  = mem_put_valid;
        obs_get_valid  = mem_get_valid;
        obs_orphan     = err_orphan;
        obs_resp_data  = resp_data;

        @(posedge CLK);
        if (RST) begin
            tagq.delete();
            memq.delete();
            rr     = 0;
            orphan = 1'b0;
        end else begin
            if (mem_get_ready && n == 0) orphan = 1'b1;
            if (gf) begin
                void'(tagq.pop_front());
                void'(memq.pop_front());
            end
            if (pf) begin
                tagq.push_back(w);
                memq.push_back(mk_resp(exp_req));
                if (RR_EN) rr = (w + 1) % NUM_REQ;
            end
        end
        @(negedge CLK);
    endtask

    // Return every outstanding response; bounded by the FIFO depth.
    task automatic drain();
        req_valid  = '0;
        resp_ready = '1;
        for (int i = 0; i < MAX_OUT + 2; i++) begin
            mem_get_ready = (memq.size() > 0);
            tick();
        end
        mem_get_ready = 1'b0;
        check("drained", 68'(tagq.size()), 68'd0);
    endtask

    task automatic rand_cycle();
        req_valid     = NUM_REQ'($urandom);
        for (int i = 0; i < NUM_REQ; i++) req_data[i*REQ_W +: REQ_W] = rand68();
        mem_put_ready = ($urandom_range(0, 9) < 7);
        resp_ready    = NUM_REQ'($urandom);
        mem_get_ready = (memq.size() > 0) && ($urandom_range(0, 1) == 1);
        tick();
    endtask

    initial begin
        RST           = 1'b1;
        req_valid     = '0;
        req_data      = '0;
        resp_ready    = '0;
        mem_put_ready = 1'b0;
        mem_get_ready = 1'b0;
        mem_get_response = '0;

        // Reset: outputs forced low even with requests and memory ready.
        tick();
        req_valid = '1; mem_put_ready = 1'b1; resp_ready = '1;
        tick();
        check("rst_put_valid", obs_put_valid, 1'b0);
        check("rst_req_ready", obs_req_ready, '0);
        RST = 1'b0;
        req_valid = '0;

        // Single requester: read of 0x100 from req 1.
        req_valid = 2'b10;
        req_data[1*REQ_W +: REQ_W] = {4'h0, 32'h0000_0100, 32'h0};
        mem_put_ready = 1'b1;
        tick();
        check("single_ready", obs_req_ready, 2'b10);
        req_valid = '0;
        mem_get_ready = 1'b1;
        tick();
        check("single_resp_valid", obs_resp_valid, 2'b10);
        check("single_resp_data", obs_resp_data, mk_resp({4'h0, 32'h0000_0100, 32'h0}));
        drain();

        // Fairness: both valid, memory always ready.
        req_valid = 2'b11;
        req_data  = {rand68(), rand68()};
        for (int k = 0; k < 4; k++) begin
            mem_get_ready = (memq.size() > 0);
            tick();
            check("fair_grant", obs_req_ready, (RR_EN && (k % 2 == 1)) ? 2'b10 : 2'b01);
        end
        drain();

        // Full FIFO: four puts, then blocked; a pop frees a slot next cycle.
        req_valid = 2'b01;
        mem_put_ready = 1'b1;
        mem_get_ready = 1'b0;
        for (int k = 0; k < MAX_OUT; k++) begin
            req_data[0 +: REQ_W] = rand68();
            tick();
            check("fill_accept", obs_req_ready, 2'b01);
        end
        tick();
        check("full_blocks", obs_put_valid, 1'b0);
        mem_get_ready = 1'b1;
        tick();
        check("full_pop_blocks", obs_put_valid, 1'b0);
        check("full_pop", obs_get_valid, 1'b1);
        mem_get_ready = 1'b0;
        tick();
        check("after_pop_accept", obs_req_ready, 2'b01);
        drain();

        // Ordering: A(req0), B(req1), C(req0); stall requester 1 on B.
        mem_put_ready = 1'b1;
        req_valid = 2'b01; req_data[0 +: REQ_W] = rand68(); tick();
        req_valid = 2'b10; req_data[REQ_W +: REQ_W] = rand68(); tick();
        req_valid = 2'b01; req_data[0 +: REQ_W] = rand68(); tick();
        req_valid = '0;
        resp_ready = 2'b01;
        mem_get_ready = 1'b1;
        tick();
        check("order_a", obs_resp_valid, 2'b01);
        tick();
        check("order_b_stall", obs_get_valid, 1'b0);
        tick();
        check("order_b_stall2", obs_get_valid, 1'b0);
        resp_ready = 2'b11;
        tick();
        check("order_b", obs_resp_valid, 2'b10);
        check("order_b_get", obs_get_valid, 1'b1);
        tick();
        check("order_c", obs_resp_valid, 2'b01);
        mem_get_ready = 1'b0;
        tick();

        // Orphan response while empty sets a sticky flag.
        check("pre_orphan", obs_orphan, 1'b0);
        mem_get_ready = 1'b1;
        tick();
        check("orphan_no_get", obs_get_valid, 1'b0);
        mem_get_ready = 1'b0;
        tick();
        check("orphan_set", obs_orphan, 1'b1);

        // Random traffic, then reset mid-stream, then more traffic.
        for (int c = 0; c < 300; c++) rand_cycle();
        check("orphan_sticky", obs_orphan, 1'b1);
        req_valid = 2'b11; mem_put_ready = 1'b1; resp_ready = '1;
        mem_get_ready = (memq.size() > 0);
        RST = 1'b1;
        tick();
        check("midrst_put_valid", obs_put_valid, 1'b0);
        check("midrst_req_ready", obs_req_ready, '0);
        check("midrst_resp_valid", obs_resp_valid, '0);
        check("midrst_get_valid", obs_get_valid, 1'b0);
        check("midrst_orphan", obs_orphan, 1'b0);
        RST = 1'b0;
        mem_get_ready = 1'b0;
        tick();
        check("post_rst_grant", obs_req_ready, 2'b01);
        for (int c = 0; c < 300; c++) rand_cycle();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
